fifo_write_arbiter: RTL and testbench

- Shares the single write port of the 8x8 byte FIFO among num_req requesters. Runs in the FIFO write-clock domain.
- Round-robin arbitration with a per-grant burst limit, so one requester cannot monopolise the FIFO.
- Drives the FIFO write enable and data. Honours the FIFO full flag as backpressure.

---
 rtl/fifo_write_arbiter.sv | 91 +++++++++
 tb/tb_fifo_write_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter for the shared byte FIFO. A grant lasts up to max_burst
// bytes. The FIFO full flag stalls the current burst without ending it.
module fifo_write_arbiter #(
    parameter int num_req   = 4,
    parameter int width     = 8,
    parameter int max_burst = 4,
    parameter int id_width  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [num_req-1:0]         req,
    input  logic [num_req*width-1:0]   req_data,
    input  logic [num_req-1:0]         req_last,
    output logic [num_req-1:0]         gnt,
    output logic                       fifo_wr,
    output logic [width-1:0]           fifo_data,
    input  logic                       fifo_full,
    output logic [id_width-1:0]        owner,
    output logic                       busy
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state;
    logic [3:0]          burst_cnt;
    logic [id_width-1:0] last_owner;
    logic [id_width-1:0] next_pick;
    logic                found;
    int                  idx;

    // Scan starts just after the previous owner, so the previous owner is considered last.
    always_comb begin
        found     = 1'b0;
        next_pick = '0;
        idx       = 0;
        for (int k = 1; k <= num_req; k++) begin
            idx = (int'(last_owner) + k) % num_req;
            if (!found && req[idx[id_width-1:0]]) begin
                found     = 1'b1;
                next_pick = idx[id_width-1:0];
            end
        end
    end

    // Grant is gated by reset so an aborted burst cannot write in the reset cycle.
    always_comb begin
        fifo_wr   = (state == BURST) && !reset && req[owner] && !fifo_full;
        gnt       = fifo_wr ? (num_req'(1) << owner) : '0;
        fifo_data = fifo_wr ? req_data[int'(owner)*width +: width] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            owner      <= '0;
            burst_cnt  <= '0;
            last_owner <= id_width'(num_req - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner     <= next_pick;
                        burst_cnt <= '0;
                        state     <= BURST;
                        busy      <= 1'b1;
                    end
                end
                BURST: begin
                    if (!req[owner]) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        last_owner <= owner;
                    end else if (fifo_wr) begin
                        burst_cnt <= burst_cnt + 4'd1;
                        if (req_last[owner] || (burst_cnt + 4'd1 == 4'(max_burst))) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            last_owner <= owner;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: each scenario task drives one cycle at a time
// and compares {busy, fifo_wr, gnt, fifo_data} and owner against hand-derived values.
module tb_fifo_write_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  gnt;
    logic        fifo_wr;
    logic [7:0]  fifo_data;
    logic        fifo_full;
    logic [1:0]  owner;
    logic        busy;
    logic [13:0] obs;

    int errors = 0;
    int checks = 0;

    fifo_write_arbiter #(.num_req(4), .width(8), .max_burst(4), .id_width(2)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_last(req_last),
        .gnt(gnt), .fifo_wr(fifo_wr), .fifo_data(fifo_data), .fifo_full(fifo_full),
        .owner(owner), .busy(busy)
    );

    assign obs = {busy, fifo_wr, gnt, fifo_data};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs on the falling edge, then settle before sampling.
    task automatic drive(input logic rst, input logic [3:0] r, input logic [3:0] l,
                         input logic f, input logic [31:0] d);
        @(negedge clk);
        reset = rst; req = r; req_last = l; fifo_full = f; req_data = d;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'b1111, 4'b0000, 1'b0, 32'h0);
            checks++;
            if (obs !== 14'h0) begin
                errors++;
                $display("FAIL reset_outputs: obs=%h exp=%h", obs, 14'h0);
            end
        end
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0);
        checks++;
        if (owner !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_owner: owner=%0d busy=%b exp owner=0 busy=0", owner, busy);
        end
    endtask

    task automatic test_single_packet();
        logic [7:0] bytes [3];
        bytes = '{8'h11, 8'h22, 8'h33};
        drive(1'b0, 4'b0001, 4'b0000, 1'b0, {24'h0, bytes[0]});
        checks++;
        if (obs !== 14'h0) begin
            errors++;
            $display("FAIL pkt_arb_cycle: obs=%h exp=%h", obs, 14'h0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b0001, (i == 2) ? 4'b0001 : 4'b0000, 1'b0, {24'h0, bytes[i]});
            checks++;
            if (obs !== {1'b1, 1'b1, 4'b0001, bytes[i]} || owner !== 2'd0) begin
                errors++;
                $display("FAIL pkt_byte%0d: obs=%h owner=%0d exp=%h owner=0", i, obs, owner,
                         {1'b1, 1'b1, 4'b0001, bytes[i]});
            end
        end
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0);
        checks++;
        if (obs !== 14'h0) begin
            errors++;
            $display("FAIL pkt_back_idle: obs=%h exp=%h", obs, 14'h0);
        end
    endtask

    task automatic test_round_robin();
        logic [13:0] exp;
        logic [1:0]  exp_own;
        for (int j = 0; j < 8; j++) begin
            drive(1'b0, 4'b0110, 4'b0110, 1'b0, 32'h44_C2_B1_00);
            if (j % 2 == 0) begin
                exp = 14'h0; exp_own = owner;
            end else if (j % 4 == 1) begin
                exp = {1'b1, 1'b1, 4'b0010, 8'hB1}; exp_own = 2'd1;
            end else begin
                exp = {1'b1, 1'b1, 4'b0100, 8'hC2}; exp_own = 2'd2;
            end
            checks++;
            if (obs !== exp || owner !== exp_own) begin
                errors++;
                $display("FAIL rr_cycle%0d: obs=%h owner=%0d exp=%h owner=%0d",
                         j, obs, owner, exp, exp_own);
            end
        end
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0);
    endtask

    task automatic test_burst_limit();
        logic [13:0] exp;
        for (int j = 0; j < 7; j++) begin
            drive(1'b0, 4'b1001, 4'b0000, 1'b0, 32'hD3_00_00_A0);
            if (j == 0 || j == 5) exp = 14'h0;
            else if (j == 6)      exp = {1'b1, 1'b1, 4'b0001, 8'hA0};
            else                  exp = {1'b1, 1'b1, 4'b1000, 8'hD3};
            checks++;
            if (obs !== exp || (exp[13] && owner !== ((j == 6) ? 2'd0 : 2'd3))) begin
                errors++;
                $display("FAIL burst_cycle%0d: obs=%h owner=%0d exp=%h", j, obs, owner, exp);
            end
        end
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0);
        checks++;
        if (obs !== {1'b1, 1'b0, 4'b0000, 8'h00}) begin
            errors++;
            $display("FAIL burst_drop: obs=%h exp=%h", obs, {1'b1, 1'b0, 4'b0000, 8'h00});
        end
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0);
    endtask

    task automatic test_full_stall();
        logic [7:0] b [10];
        logic       f [10];
        logic [13:0] exp;
        b = '{8'h41, 8'h41, 8'h42, 8'h43, 8'h43, 8'h43, 8'h43, 8'h44, 8'h00, 8'h00};
        f = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int j = 0; j < 9; j++) begin
            drive(1'b0, (j == 8) ? 4'b0000 : 4'b0001, 4'b0000, f[j], {24'h0, b[j]});
            if (j == 0 || j == 8)     exp = 14'h0;
            else if (j >= 3 && j <= 5) exp = {1'b1, 1'b0, 4'b0000, 8'h00};
            else                       exp = {1'b1, 1'b1, 4'b0001, b[j]};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL full_cycle%0d: obs=%h exp=%h", j, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        drive(1'b0, 4'b1111, 4'b0000, 1'b0, 32'h53_52_51_50);
        drive(1'b0, 4'b1111, 4'b0000, 1'b0, 32'h53_52_51_50);
        checks++;
        if (obs !== {1'b1, 1'b1, 4'b0010, 8'h51} || owner !== 2'd1) begin
            errors++;
            $display("FAIL rst_pre_byte: obs=%h owner=%0d exp=%h owner=1", obs, owner,
                     {1'b1, 1'b1, 4'b0010, 8'h51});
        end
        drive(1'b1, 4'b1111, 4'b0000, 1'b0, 32'h53_52_51_50);
        checks++;
        if (fifo_wr !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL rst_cycle_write: wr=%b gnt=%b exp wr=0 gnt=0000", fifo_wr, gnt);
        end
        drive(1'b0, 4'b1111, 4'b0000, 1'b0, 32'h53_52_51_50);
        checks++;
        if (obs !== 14'h0 || owner !== 2'd0) begin
            errors++;
            $display("FAIL rst_after: obs=%h owner=%0d exp=%h owner=0", obs, owner, 14'h0);
        end
        drive(1'b0, 4'b1111, 4'b0000, 1'b0, 32'h53_52_51_50);
        checks++;
        if (obs !== {1'b1, 1'b1, 4'b0001, 8'h50} || owner !== 2'd0) begin
            errors++;
            $display("FAIL rst_rearb: obs=%h owner=%0d exp=%h owner=0", obs, owner,
                     {1'b1, 1'b1, 4'b0001, 8'h50});
        end
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0);
    endtask

    task automatic test_owner_drop();
        logic [3:0] after [3];
        logic [1:0] nxt   [3];
        logic [7:0] dat   [3];
        logic [13:0] exp;
        after = '{4'b1011, 4'b0011, 4'b0010};
        nxt   = '{2'd3, 2'd0, 2'd1};
        dat   = '{8'h63, 8'h60, 8'h61};
        for (int s = 0; s < 3; s++) begin
            drive(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0);
            drive(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0);
            drive(1'b0, 4'b0100, 4'b0000, 1'b0, 32'h63_62_61_60);
            drive(1'b0, 4'b0100, 4'b0000, 1'b0, 32'h63_62_61_60);
            checks++;
            if (obs !== {1'b1, 1'b1, 4'b0100, 8'h62} || owner !== 2'd2) begin
                errors++;
                $display("FAIL drop%0d_first: obs=%h owner=%0d exp=%h owner=2", s, obs, owner,
                         {1'b1, 1'b1, 4'b0100, 8'h62});
            end
            drive(1'b0, after[s], 4'b0000, 1'b0, 32'h63_62_61_60);
            checks++;
            if (obs !== {1'b1, 1'b0, 4'b0000, 8'h00}) begin
                errors++;
                $display("FAIL drop%0d_stall: obs=%h exp=%h", s, obs,
                         {1'b1, 1'b0, 4'b0000, 8'h00});
            end
            drive(1'b0, after[s], 4'b0000, 1'b0, 32'h63_62_61_60);
            checks++;
            if (obs !== 14'h0) begin
                errors++;
                $display("FAIL drop%0d_idle: obs=%h exp=%h", s, obs, 14'h0);
            end
            drive(1'b0, after[s], 4'b0000, 1'b0, 32'h63_62_61_60);
            exp = {1'b1, 1'b1, 4'b0001 << nxt[s], dat[s]};
            checks++;
            if (obs !== exp || owner !== nxt[s]) begin
                errors++;
                $display("FAIL drop%0d_next: obs=%h owner=%0d exp=%h owner=%0d", s, obs, owner,
                         exp, nxt[s]);
            end
        end
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; req = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_burst_limit();
        test_full_stall();
        test_reset_mid_burst();
        test_owner_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
